// File: rtl/fpu_axis_pipe.sv
// fpu_axis_pipe
// -------------
// Pipelined AXI4-Stream front end for a two-operand floating-point IP core
// (adder/subtractor class). One operation is issued every two cycles:
//   - an IDLE cycle accepts the request;
//   - a SEND cycle offers the operands to the IP core.
// Up to DEPTH operations may be in flight at once. The destination tag of
// each operation is held in an in-order FIFO and returned with its result.
//
// Optional feature (macro FPU_AXIS_PIPE_OP_EN):
//   defined   - adds the sub input and the axis_op_* operation channel.
//               axis_op_tdata = {7'b0, sub}. SEND also waits for the
//               op-channel handshake.
//   undefined - addition only; SEND waits on the A and B channels only.
//
// Ports:
//   clk, rstn            clock; synchronous active-low reset. rstn also
//                        resets the IP core.
//   en, adata, bdata,    issue request with operands and destination tag.
//   tag_in               The request is sampled only while busy is 0.
//   sub                  1 = A-B, 0 = A+B (macro only)
//   busy                 the issue port cannot accept this cycle
//   done                 one-cycle pulse; result and tag_out are valid
//   result, tag_out      retired result and its tag
//   axis_a_*, axis_b_*   operand channels to the IP core
//   axis_op_*            operation channel to the IP core (macro only)
//   axis_result_*        result channel from the IP core
module fpu_axis_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] adata,
  input  logic [WIDTH-1:0] bdata,
  input  logic [TAG_W-1:0] tag_in,
`ifdef FPU_AXIS_PIPE_OP_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic [WIDTH-1:0] axis_a_tdata,
  output logic             axis_a_tvalid,
  input  logic             axis_a_tready,
  output logic [WIDTH-1:0] axis_b_tdata,
  output logic             axis_b_tvalid,
  input  logic             axis_b_tready,
`ifdef FPU_AXIS_PIPE_OP_EN
  output logic [7:0]       axis_op_tdata,
  output logic             axis_op_tvalid,
  input  logic             axis_op_tready,
`endif
  input  logic [WIDTH-1:0] axis_result_tdata,
  input  logic             axis_result_tvalid,
  output logic             axis_result_tready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t           state_reg, state_next;
  logic             a_valid_reg, a_valid_next;
  logic             b_valid_reg, b_valid_next;
  logic [WIDTH-1:0] a_data_reg, b_data_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;
  logic [TAG_W-1:0] tag_out_reg;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic             issue;
  logic             retire;
  logic             full;
  logic             all_clear_next;

`ifdef FPU_AXIS_PIPE_OP_EN
  logic             op_valid_reg, op_valid_next;
  logic             sub_reg;
`endif

  assign full   = (count_reg == CW'(DEPTH));
  assign busy   = (state_reg == SEND) || full;
  // In IDLE, busy reduces to full, so this is also the FSM's accept condition.
  assign issue  = en && !busy;
  assign retire = axis_result_tvalid && axis_result_tready;

  assign axis_result_tready = (count_reg != '0);
  assign axis_a_tdata       = a_data_reg;
  assign axis_a_tvalid      = a_valid_reg;
  assign axis_b_tdata       = b_data_reg;
  assign axis_b_tvalid      = b_valid_reg;
  assign done               = done_reg;
  assign result             = result_reg;
  assign tag_out            = tag_out_reg;

`ifdef FPU_AXIS_PIPE_OP_EN
  assign axis_op_tdata  = {7'b0, sub_reg};
  assign axis_op_tvalid = op_valid_reg;
`endif

  // Issue FSM. Each channel's valid drops on its own handshake. The FSM
  // returns to IDLE once every channel has been taken, so a stalled
  // channel does not hold back the others.
  always_comb begin
    state_next     = state_reg;
    a_valid_next   = a_valid_reg;
    b_valid_next   = b_valid_reg;
    all_clear_next = 1'b0;
`ifdef FPU_AXIS_PIPE_OP_EN
    op_valid_next  = op_valid_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (issue) begin
          a_valid_next  = 1'b1;
          b_valid_next  = 1'b1;
`ifdef FPU_AXIS_PIPE_OP_EN
          op_valid_next = 1'b1;
`endif
          state_next    = SEND;
        end
      end
      SEND: begin
        a_valid_next   = a_valid_reg && !axis_a_tready;
        b_valid_next   = b_valid_reg && !axis_b_tready;
`ifdef FPU_AXIS_PIPE_OP_EN
        op_valid_next  = op_valid_reg && !axis_op_tready;
        all_clear_next = !a_valid_next && !b_valid_next && !op_valid_next;
`else
        all_clear_next = !a_valid_next && !b_valid_next;
`endif
        if (all_clear_next) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outstanding count. An issue and a retire in the same cycle cancel out.
  always_comb begin
    count_next = count_reg;
    case ({issue, retire})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      a_valid_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
      a_data_reg   <= '0;
      b_data_reg   <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      tag_out_reg  <= '0;
`ifdef FPU_AXIS_PIPE_OP_EN
      op_valid_reg <= 1'b0;
      sub_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      a_valid_reg  <= a_valid_next;
      b_valid_reg  <= b_valid_next;
      count_reg    <= count_next;
      done_reg     <= retire;
`ifdef FPU_AXIS_PIPE_OP_EN
      op_valid_reg <= op_valid_next;
`endif
      // Operand registers load only on acceptance. They therefore stay
      // stable for as long as their tvalid is held.
      if (issue) begin
        a_data_reg <= adata;
        b_data_reg <= bdata;
`ifdef FPU_AXIS_PIPE_OP_EN
        sub_reg    <= sub;
`endif
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (retire) begin
        result_reg  <= axis_result_tdata;
        tag_out_reg <= tag_mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Tag storage with no reset, so the FIFO maps onto RAM. A push never
  // aliases the head being popped: popping needs count >= 1, and pushing
  // needs count < DEPTH.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr_reg] <= tag_in;
    end
  end

endmodule
